eds_encode_decimate: RTL

Sits between `encode_align` and the EDS encode CDC FIFO (`sync_eds_encode_fifo`) in the `clk_i` domain. Decimates the aligned 100 MHz EDS encoder stream to the EDS sample rate (48 kHz) using an exact fractional phase accumulator rather than a fixed 2083-cycle counter. Packs each kept {W, X} pair into one 64-bit FIFO word, frames each scan with start/end pulses, and accounts for words dropped on FIFO full.

---
 rtl/eds_pkg.sv | 18 +
 rtl/eds_rate_nco.sv | 44 ++++
 rtl/eds_encode_decimate.sv | 131 +++++++++++++
 3 files changed

// File: rtl/eds_pkg.sv
// rtl/eds_pkg.sv - shared types, default rates and word packing for the EDS encode decimator
package eds_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      END  = 2'd2
   } eds_state_e;

   localparam int unsigned DEF_RATE_STEP = 48;
   localparam int unsigned DEF_RATE_MOD  = 100000;

   // W occupies the upper half of the FIFO word, X the lower half
   function automatic logic [63:0] pack_word(input logic [31:0] w, input logic [31:0] x);
      return {w, x};
   endfunction

endpackage

// File: rtl/eds_rate_nco.sv
// rtl/eds_rate_nco.sv - fractional phase accumulator deciding which valid samples are kept
module eds_rate_nco
   import eds_pkg::*;
#(
   parameter int unsigned RATE_STEP = DEF_RATE_STEP,
   parameter int unsigned RATE_MOD  = DEF_RATE_MOD,
   parameter int unsigned ACC_W     = 17
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic step_en,
   output logic keep
);

   localparam int unsigned PRE_VAL = RATE_MOD - RATE_STEP;
   localparam logic [ACC_W:0]   STEP_X  = RATE_STEP[ACC_W:0];
   localparam logic [ACC_W:0]   MOD_X   = RATE_MOD[ACC_W:0];
   localparam logic [ACC_W-1:0] PRELOAD = PRE_VAL[ACC_W-1:0];

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W:0]   sum;

   // One extra bit on the sum so the compare against the modulus cannot wrap
   always_comb begin
      sum  = {1'b0, acc_q} + STEP_X;
      keep = step_en && (sum >= MOD_X);
      acc_d = acc_q;
      if (load) begin
         acc_d = PRELOAD;
      end else if (step_en) begin
         acc_d = keep ? (sum[ACC_W-1:0] - MOD_X[ACC_W-1:0]) : sum[ACC_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/eds_encode_decimate.sv
// rtl/eds_encode_decimate.sv - decimates aligned encoder samples to the EDS rate and frames scans
module eds_encode_decimate
   import eds_pkg::*;
#(
   parameter int unsigned RATE_STEP = DEF_RATE_STEP,
   parameter int unsigned RATE_MOD  = DEF_RATE_MOD,
   parameter int unsigned ACC_W     = 17
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        eds_scan_en_i,
   input  logic        eds_encode_en_i,
   input  logic [31:0] eds_encode_w_i,
   input  logic [31:0] eds_encode_x_i,
   input  logic        fifo_full_i,
   output logic        fifo_wr_en_o,
   output logic [63:0] fifo_din_o,
   output logic        frame_start_o,
   output logic        frame_end_o,
   output logic [31:0] sample_cnt_o,
   output logic [15:0] drop_cnt_o,
   output logic        overflow_o
);

   eds_state_e  state_q, state_d;
   logic        load, step_en, keep;
   logic        wr_q, wr_d;
   logic [63:0] din_q, din_d;
   logic        start_q, start_d;
   logic        end_q, end_d;
   logic [31:0] cnt_q, cnt_d;
   logic [15:0] drop_q, drop_d;
   logic        ovf_q, ovf_d;

   eds_rate_nco #(
      .RATE_STEP (RATE_STEP),
      .RATE_MOD  (RATE_MOD),
      .ACC_W     (ACC_W)
   ) u_nco (
      .clk     (clk_i),
      .rst     (rst_i),
      .load    (load),
      .step_en (step_en),
      .keep    (keep)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Samples only advance the phase in RUN while the scan window is still open
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (eds_scan_en_i) begin
               state_d = RUN;
               load    = 1'b1;
            end
         end
         RUN: begin
            if (!eds_scan_en_i) begin
               state_d = END;
            end else begin
               step_en = eds_encode_en_i;
            end
         end
         END:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_d    = keep && !fifo_full_i;
      din_d   = wr_d ? pack_word(eds_encode_w_i, eds_encode_x_i) : din_q;
      start_d = (state_q == IDLE) && eds_scan_en_i;
      end_d   = (state_q == RUN) && !eds_scan_en_i;
      cnt_d   = cnt_q;
      drop_d  = drop_q;
      ovf_d   = ovf_q;
      if (start_d) begin
         cnt_d  = '0;
         drop_d = '0;
         ovf_d  = 1'b0;
      end else if (keep) begin
         if (fifo_full_i) begin
            ovf_d = 1'b1;
            if (drop_q != 16'hFFFF) begin
               drop_d = drop_q + 16'd1;
            end
         end else begin
            cnt_d = cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q    <= 1'b0;
         din_q   <= '0;
         start_q <= 1'b0;
         end_q   <= 1'b0;
         cnt_q   <= '0;
         drop_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         din_q   <= din_d;
         start_q <= start_d;
         end_q   <= end_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
         ovf_q   <= ovf_d;
      end
   end

   assign fifo_wr_en_o  = wr_q;
   assign fifo_din_o    = din_q;
   assign frame_start_o = start_q;
   assign frame_end_o   = end_q;
   assign sample_cnt_o  = cnt_q;
   assign drop_cnt_o    = drop_q;
   assign overflow_o    = ovf_q;

endmodule
